// File: rtl/spi_bus_bridge_slave.sv
// ---------------------------------------------------------------------------
// spi_bus_bridge_slave
//
// SPI responder for the single-clock CS/MOSI/MISO frame protocol. Each frame
// becomes one req/ack bus transaction. Frames are LSB first, one bit per clk
// while cs is low:
//   bit0 = op (1 write, 0 read), addr[0..7], then data[0..7] for writes only.
// Read data is returned on miso for the 8 cycles that follow the ready pulse.
//
// Optional build macro: SPI_BRIDGE_PARITY_EN
//   When defined, a 9th miso bit (even parity of the read data) is sent after
//   the data bits, and op_done follows it. The write path does not change.
//
// Ports:
//   clk        single clock, all logic on posedge
//   rst        synchronous active-high reset
//   cs         frame select, active low
//   mosi       serial data from master
//   miso       serial read data to master
//   ready      one-cycle pulse, read data starts on the following cycle
//   op_done    one-cycle pulse at the end of every transaction
//   err        one-cycle pulse with op_done on a failed transaction
//   bus_req    bus request, held until bus_ack or timeout
//   bus_wr     1 = write, 0 = read
//   bus_addr   transaction address
//   bus_wdata  write data
//   bus_ack    one-cycle completion strobe from the bus
//   bus_rdata  read data, valid with bus_ack
// ---------------------------------------------------------------------------
module spi_bus_bridge_slave #(
    parameter int unsigned ADDR_LIMIT  = 32,
    parameter int unsigned ACK_TIMEOUT = 16   // must be 1..255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs,
    input  logic       mosi,
    output logic       miso,
    output logic       ready,
    output logic       op_done,
    output logic       err,
    output logic       bus_req,
    output logic       bus_wr,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_wdata,
    input  logic       bus_ack,
    input  logic [7:0] bus_rdata
);

`ifdef SPI_BRIDGE_PARITY_EN
    localparam int unsigned TX_BITS = 9;
`else
    localparam int unsigned TX_BITS = 8;
`endif

    typedef enum logic [3:0] {
        IDLE,
        RX_ADDR,
        RX_DATA,
        BUS_WR,
        BUS_RD,
        READY,
        TX_DATA,
        DONE,
        WAIT_CS
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q,   cnt_d;
    logic        op_q,    op_d;
    logic [7:0]  addr_q,  addr_d;
    logic [7:0]  data_q,  data_d;
    logic [8:0]  tx_q,    tx_d;
    logic        err_q,   err_d;
    logic        acked_q, acked_d;

    // Address with the current mosi bit shifted in; complete on the last
    // address bit, so the range check can steer the very next state.
    logic [7:0]  addr_shift;
    logic        shift_bad;
    logic        hold_bad;
    logic        tx_par;

    assign addr_shift = {mosi, addr_q[7:1]};
    assign shift_bad  = (32'(addr_shift) >= ADDR_LIMIT);
    assign hold_bad   = (32'(addr_q) >= ADDR_LIMIT);

`ifdef SPI_BRIDGE_PARITY_EN
    assign tx_par = ^bus_rdata;
`else
    assign tx_par = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            tx_q    <= '0;
            err_q   <= 1'b0;
            acked_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
            err_q   <= err_d;
            acked_q <= acked_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        data_d  = data_q;
        tx_d    = tx_q;
        err_d   = err_q;
        acked_d = acked_q;

        unique case (state_q)
            IDLE: begin
                if (!cs) begin
                    op_d    = mosi;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    acked_d = 1'b0;
                    state_d = RX_ADDR;
                end
            end

            RX_ADDR: begin
                if (cs) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    addr_d = addr_shift;
                    cnt_d  = cnt_q + 8'd1;
                    if (cnt_q == 8'd7) begin
                        cnt_d = '0;
                        if (op_q) begin
                            state_d = RX_DATA;
                        end else if (shift_bad) begin
                            // Out-of-range read still answers with 0x00.
                            err_d   = 1'b1;
                            tx_d    = '0;
                            state_d = READY;
                        end else begin
                            state_d = BUS_RD;
                        end
                    end
                end
            end

            RX_DATA: begin
                if (cs) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    data_d = {mosi, data_q[7:1]};
                    cnt_d  = cnt_q + 8'd1;
                    if (cnt_q == 8'd7) begin
                        cnt_d = '0;
                        if (hold_bad) begin
                            err_d   = 1'b1;
                            state_d = DONE;
                        end else begin
                            state_d = BUS_WR;
                        end
                    end
                end
            end

            BUS_WR: begin
                // One extra cycle after the ack keeps the write op_done two
                // cycles behind bus_ack.
                if (acked_q) begin
                    state_d = DONE;
                end else if (bus_ack) begin
                    acked_d = 1'b1;
                end else if (cnt_q == 8'(ACK_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            BUS_RD: begin
                if (bus_ack) begin
                    tx_d    = {tx_par, bus_rdata};
                    state_d = READY;
                end else if (cnt_q == 8'(ACK_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    tx_d    = '0;
                    state_d = READY;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            READY: begin
                cnt_d   = '0;
                state_d = TX_DATA;
            end

            TX_DATA: begin
                tx_d  = {1'b0, tx_q[8:1]};
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'(TX_BITS - 1)) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                state_d = cs ? IDLE : WAIT_CS;
            end

            WAIT_CS: begin
                if (cs) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs, decoded from registered state so reset clears them at once
    // ------------------------------------------------------------------
    always_comb begin
        miso      = 1'b0;
        ready     = 1'b0;
        op_done   = 1'b0;
        err       = 1'b0;
        bus_req   = 1'b0;
        bus_wr    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;

        unique case (state_q)
            BUS_WR: begin
                bus_req   = !acked_q;
                bus_wr    = 1'b1;
                bus_addr  = addr_q;
                bus_wdata = data_q;
            end
            BUS_RD: begin
                bus_req  = 1'b1;
                bus_addr = addr_q;
            end
            READY:   ready = 1'b1;
            TX_DATA: miso  = tx_q[0];
            DONE: begin
                op_done = 1'b1;
                err     = err_q;
            end
            default: ;
        endcase
    end

endmodule
